// File: rtl/im2col_streamer.sv
// Streams 3x3 im2col windows from a raster pixel stream using two line buffers.
// One output register stage; upstream stalls while a window is held.
module im2col_streamer #(
   parameter  int IMG_W  = 28,
   parameter  int IMG_H  = 28,
   parameter  int K      = 3,
   parameter  int DATA_W = 8,
   localparam int OUT_W  = IMG_W - K + 1,
   localparam int OUT_N  = OUT_W * (IMG_H - K + 1),
   localparam int IDX_W  = $clog2(OUT_N)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [DATA_W-1:0]     pix_data,
   output logic                  col_valid,
   input  logic                  col_ready,
   output logic [9*DATA_W-1:0]   col_data,
   output logic [IDX_W-1:0]      col_idx,
   output logic                  col_last,
   output logic                  frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]     c;
   logic [RW-1:0]     r;
   logic [IDX_W-1:0]  out_cnt;
   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];
   logic [DATA_W-1:0] win [3][3];

   logic accept;
   logic emit;
   logic xfer;
   logic c_end;
   logic r_end;
   logic cnt_end;

   assign pix_ready = !reset && (!col_valid || col_ready);
   assign accept    = pix_valid && pix_ready;
   assign xfer      = col_valid && col_ready;
   assign c_end     = (c == CW'(IMG_W - 1));
   assign r_end     = (r == RW'(IMG_H - 1));
   assign cnt_end   = (out_cnt == IDX_W'(OUT_N - 1));
   assign emit      = accept && (r >= RW'(K - 1)) && (c >= CW'(K - 1));

   // Line buffers carry no reset: stale rows are never emitted.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[c] <= lb0[c];
         lb0[c] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c          <= '0;
         r          <= '0;
         out_cnt    <= '0;
         win        <= '{default: '0};
         col_valid  <= 1'b0;
         col_idx    <= '0;
         col_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= xfer && col_last;
         if (xfer) begin
            col_valid <= 1'b0;
            col_last  <= 1'b0;
         end
         if (accept) begin
            for (int kr = 0; kr < 3; kr++) begin
               win[kr][0] <= win[kr][1];
               win[kr][1] <= win[kr][2];
            end
            win[0][2] <= lb1[c];
            win[1][2] <= lb0[c];
            win[2][2] <= pix_data;
            if (c_end) begin
               c <= '0;
               r <= r_end ? '0 : r + 1'b1;
            end else begin
               c <= c + 1'b1;
            end
         end
         // A new window may load in the same cycle the previous one leaves.
         if (emit) begin
            col_valid <= 1'b1;
            col_idx   <= out_cnt;
            col_last  <= cnt_end;
            out_cnt   <= cnt_end ? '0 : out_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      col_data = '0;
      for (int kr = 0; kr < 3; kr++) begin
         for (int kc = 0; kc < 3; kc++) begin
            col_data[(kr*3+kc)*DATA_W +: DATA_W] = win[kr][kc];
         end
      end
   end

endmodule
